// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan driver: segment encodings and
// anode defaults. All segment patterns are active-low {g,f,e,d,c,b,a}.
package ssd_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/ssd_hex7seg_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex7seg_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver. The display word is captured
// once per scan frame into a shadow register so a frame never mixes two values.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int DIV_WIDTH = 18,
    parameter int DIV_COUNT = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        blank_lz,
    input  logic        freeze,
    input  logic [3:0]  dp_mask,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic [3:0]  anode,
    output logic        frame_start
);

    localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_COUNT - 1);

    logic [DIV_WIDTH-1:0] cnt;
    slot_t                idx;
    logic [15:0]          shadow;
    logic                 tick;
    logic                 load;
    logic [3:0]           nib;
    logic [6:0]           seg;
    logic                 lead_zero;
    logic                 blank;

    assign tick = (cnt == CNT_MAX);
    assign load = tick && (idx == 2'd3) && !freeze;

    // Slot 0 is the thousands digit, so higher slots read lower nibbles.
    assign nib = shadow[4'd15 - {idx, 2'b00} -: 4];

    hex7seg_decode u_decode (
        .nib (nib),
        .seg (seg)
    );

    // A slot is a leading zero when it and every more-significant nibble are zero;
    // the ones slot always shows its digit.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
        lead_zero = 1'b0;
        case (idx)
            2'd0:    lead_zero = (shadow[15:12] == 4'h0);
            2'd1:    lead_zero = (shadow[15:8]  == 8'h00);
            2'd2:    lead_zero = (shadow[15:4]  == 12'h000);
            default: lead_zero = 1'b0;
        endcase
        blank = blank_lz && lead_zero;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= '0;
            idx         <= '0;
            shadow      <= 16'h0000;
            frame_start <= 1'b0;
            anode       <= ANODE_OFF;
            cathode     <= SEG_BLANK;
            dp          <= 1'b1;
        end else begin
            cnt         <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
            frame_start <= load;
            if (load) begin
                shadow <= value;
            end
            anode   <= ~(4'b0001 << idx);
            cathode <= blank ? SEG_BLANK : seg;
            dp      <= ~dp_mask[idx];
        end
    end

endmodule
